// File: rtl/config_tp_ram_port_arbiter_if.sv
// Avalon-MM master-side bundle for one port of the RAM arbiter.
// Signals: address, byteenable, read, write, writedata, waitrequest, readdata, readdatavalid.
interface config_tp_ram_port_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
);
   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/config_tp_ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port 2 between masters m0 and m1 (bounded hold).
// Ports: clk, reset (async high), m0/m1 Avalon-MM slave bundles, ram_* port-2 pins.
// Optional CONFIG_TP_ARB_STATS_EN adds stat_acc0, stat_acc1, stat_stall counters.
module config_tp_ram_port_arbiter #(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 32,
   parameter int BE_W     = 4,
   parameter int HOLD_MAX = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   config_tp_ram_port_arbiter_if.slave m0,
   config_tp_ram_port_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]    ram_address,
   output logic [BE_W-1:0]      ram_byteenable,
   output logic                 ram_chipselect,
   output logic                 ram_write,
   output logic [DATA_W-1:0]    ram_writedata,
   output logic                 ram_clken,
   input  logic [DATA_W-1:0]    ram_readdata
`ifdef CONFIG_TP_ARB_STATS_EN
   ,
   output logic [31:0]          stat_acc0,
   output logic [31:0]          stat_acc1,
   output logic [31:0]          stat_stall
`endif
);

   localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HC_W-1:0] HC_TOP = HC_W'(HOLD_MAX - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t          state;
   logic            last;
   logic [HC_W-1:0] hold_cnt;
   logic            rd_pend;
   logic            rd_id;

   logic req0, req1;
   logic g0, g1;
   logic acc0, acc1;
   logic accept;

   assign req0   = m0.read | m0.write;
   assign req1   = m1.read | m1.write;
   assign g0     = (state == GNT0);
   assign g1     = (state == GNT1);
   assign acc0   = g0 & req0;
   assign acc1   = g1 & req1;
   assign accept = acc0 | acc1;

   assign m0.waitrequest = ~g0;
   assign m1.waitrequest = ~g1;

   assign ram_address    = g1 ? m1.address    : m0.address;
   assign ram_byteenable = g1 ? m1.byteenable : m0.byteenable;
   assign ram_writedata  = g1 ? m1.writedata  : m0.writedata;
   assign ram_chipselect = accept;
   // read+write together is treated as a write
   assign ram_write      = (acc0 & m0.write) | (acc1 & m1.write);
   assign ram_clken      = 1'b1;

   assign m0.readdata      = ram_readdata;
   assign m1.readdata      = ram_readdata;
   assign m0.readdatavalid = rd_pend & ~rd_id;
   assign m1.readdatavalid = rd_pend &  rd_id;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         last     <= 1'b1;
         hold_cnt <= '0;
         rd_pend  <= 1'b0;
         rd_id    <= 1'b0;
      end else begin
         rd_pend <= accept & ~ram_write;
         rd_id   <= acc1;
         unique case (state)
            IDLE: begin
               hold_cnt <= '0;
               if (req0 & req1)
                  state <= last ? GNT0 : GNT1;
               else if (req0)
                  state <= GNT0;
               else if (req1)
                  state <= GNT1;
            end
            GNT0: begin
               if (!req0) begin
                  hold_cnt <= '0;
                  state    <= req1 ? GNT1 : IDLE;
               end else begin
                  last <= 1'b0;
                  // saturate while m1 is idle so m0 can stream
                  if (hold_cnt == HC_TOP) begin
                     if (req1) begin
                        state    <= GNT1;
                        hold_cnt <= '0;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + HC_W'(1);
                  end
               end
            end
            GNT1: begin
               if (!req1) begin
                  hold_cnt <= '0;
                  state    <= req0 ? GNT0 : IDLE;
               end else begin
                  last <= 1'b1;
                  if (hold_cnt == HC_TOP) begin
                     if (req0) begin
                        state    <= GNT0;
                        hold_cnt <= '0;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + HC_W'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               hold_cnt <= '0;
            end
         endcase
      end
   end

`ifdef CONFIG_TP_ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_acc0  <= '0;
         stat_acc1  <= '0;
         stat_stall <= '0;
      end else begin
         if (acc0)
            stat_acc0 <= stat_acc0 + 32'd1;
         if (acc1)
            stat_acc1 <= stat_acc1 + 32'd1;
         if ((req0 & ~acc0) | (req1 & ~acc1))
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
